// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse decoder.
// Build option: define MORSE_DIGITS_EN to accept 5-symbol digit patterns.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    localparam int CNT_W  = 8;
    localparam int PAT_W  = 5;
    localparam int CODE_W = 6;
    localparam int LEN_W  = 3;

    localparam logic [CODE_W-1:0] CODE_A       = 6'd0;
    localparam logic [CODE_W-1:0] CODE_DIGIT0  = 6'd26;
    localparam logic [CODE_W-1:0] CODE_INVALID = 6'd63;

    localparam logic [LEN_W-1:0] MAX_LEN_LETTERS = 3'd4;
    localparam logic [LEN_W-1:0] MAX_LEN_DIGITS  = 3'd5;

`ifdef MORSE_DIGITS_EN
    localparam logic [LEN_W-1:0] MAX_LEN = MAX_LEN_DIGITS;
`else
    localparam logic [LEN_W-1:0] MAX_LEN = MAX_LEN_LETTERS;
`endif

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational pattern/length to symbol-code table for the Morse decoder.
// Build option: MORSE_DIGITS_EN adds the ten 5-symbol digit entries.
module morse_lut
    import morse_pkg::*;
(
    input  logic [PAT_W-1:0]  pattern,
    input  logic [LEN_W-1:0]  len,
    output logic [CODE_W-1:0] code
);

    // Bit 0 holds the first symbol, dot=0, dash=1; bits at or above len are zero.
    always_comb begin
        code = CODE_INVALID;
        case (len)
            3'd1: begin
                case (pattern)
                    5'd0:    code = CODE_A + 6'd4;   // E .
                    5'd1:    code = CODE_A + 6'd19;  // T -
                    default: code = CODE_INVALID;
                endcase
            end
            3'd2: begin
                case (pattern)
                    5'd2:    code = CODE_A + 6'd0;   // A .-
                    5'd0:    code = CODE_A + 6'd8;   // I ..
                    5'd3:    code = CODE_A + 6'd12;  // M --
                    5'd1:    code = CODE_A + 6'd13;  // N -.
                    default: code = CODE_INVALID;
                endcase
            end
            3'd3: begin
                case (pattern)
                    5'd1:    code = CODE_A + 6'd3;   // D -..
                    5'd3:    code = CODE_A + 6'd6;   // G --.
                    5'd5:    code = CODE_A + 6'd10;  // K -.-
                    5'd7:    code = CODE_A + 6'd14;  // O ---
                    5'd2:    code = CODE_A + 6'd17;  // R .-.
                    5'd0:    code = CODE_A + 6'd18;  // S ...
                    5'd4:    code = CODE_A + 6'd20;  // U ..-
                    5'd6:    code = CODE_A + 6'd22;  // W .--
                    default: code = CODE_INVALID;
                endcase
            end
            3'd4: begin
                case (pattern)
                    5'd1:    code = CODE_A + 6'd1;   // B -...
                    5'd5:    code = CODE_A + 6'd2;   // C -.-.
                    5'd4:    code = CODE_A + 6'd5;   // F ..-.
                    5'd0:    code = CODE_A + 6'd7;   // H ....
                    5'd14:   code = CODE_A + 6'd9;   // J .---
                    5'd2:    code = CODE_A + 6'd11;  // L .-..
                    5'd6:    code = CODE_A + 6'd15;  // P .--.
                    5'd11:   code = CODE_A + 6'd16;  // Q --.-
                    5'd8:    code = CODE_A + 6'd21;  // V ...-
                    5'd9:    code = CODE_A + 6'd23;  // X -..-
                    5'd13:   code = CODE_A + 6'd24;  // Y -.--
                    5'd3:    code = CODE_A + 6'd25;  // Z --..
                    default: code = CODE_INVALID;
                endcase
            end
`ifdef MORSE_DIGITS_EN
            3'd5: begin
                case (pattern)
                    5'd31:   code = CODE_DIGIT0 + 6'd0;  // 0 -----
                    5'd30:   code = CODE_DIGIT0 + 6'd1;  // 1 .----
                    5'd28:   code = CODE_DIGIT0 + 6'd2;  // 2 ..---
                    5'd24:   code = CODE_DIGIT0 + 6'd3;  // 3 ...--
                    5'd16:   code = CODE_DIGIT0 + 6'd4;  // 4 ....-
                    5'd0:    code = CODE_DIGIT0 + 6'd5;  // 5 .....
                    5'd1:    code = CODE_DIGIT0 + 6'd6;  // 6 -....
                    5'd3:    code = CODE_DIGIT0 + 6'd7;  // 7 --...
                    5'd7:    code = CODE_DIGIT0 + 6'd8;  // 8 ---..
                    5'd15:   code = CODE_DIGIT0 + 6'd9;  // 9 ----.
                    default: code = CODE_INVALID;
                endcase
            end
`endif
            default: code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Key-level Morse decoder: times presses and gaps in Tick units and emits one code per letter.
// Build option: define MORSE_DIGITS_EN to raise the letter length to 5 and decode digits.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int DOT_MAX    = 2,
    parameter int GAP_LETTER = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Tick,
    input  logic              Key,
    output logic [CODE_W-1:0] Code,
    output logic              Code_Valid,
    output logic [LEN_W-1:0]  Sym_Count,
    output logic              Busy,
    output state_t            Dbg_State
);

    localparam logic [CNT_W-1:0] DOT_LIMIT = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(GAP_LETTER);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [LEN_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic               ovf_q, ovf_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  lut_code;
    logic               is_dash;

    morse_lut u_lut (
        .pattern (pattern_q),
        .len     (sym_cnt_q),
        .code    (lut_code)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pattern_q <= '0;
            sym_cnt_q <= '0;
            ovf_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            sym_cnt_q <= sym_cnt_d;
            ovf_q     <= ovf_d;
            code_q    <= code_d;
        end
    end

    // A Key edge always wins over a coincident Tick: the edge branch is taken
    // first and the counter is cleared rather than incremented.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        sym_cnt_d = sym_cnt_q;
        ovf_d     = ovf_q;
        code_d    = code_q;
        cnt_inc   = sat_inc(cnt_q);
        is_dash   = (cnt_q > DOT_LIMIT);

        case (state_q)
            ST_IDLE: begin
                pattern_d = '0;
                sym_cnt_d = '0;
                ovf_d     = 1'b0;
                if (Key) begin
                    state_d = ST_MARK;
                    cnt_d   = '0;
                end
            end

            ST_MARK: begin
                if (!Key) begin
                    state_d = ST_SPACE;
                    cnt_d   = '0;
                    if (sym_cnt_q == MAX_LEN) begin
                        ovf_d = 1'b1;
                    end else begin
                        pattern_d[sym_cnt_q] = is_dash;
                        sym_cnt_d            = sym_cnt_q + 1'b1;
                    end
                end else if (Tick) begin
                    cnt_d = cnt_inc;
                end
            end

            ST_SPACE: begin
                if (Key) begin
                    state_d = ST_MARK;
                    cnt_d   = '0;
                end else if (Tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= GAP_LIMIT) begin
                        state_d = ST_EMIT;
                        code_d  = ovf_q ? CODE_INVALID : lut_code;
                    end
                end
            end

            ST_EMIT: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                pattern_d = '0;
                sym_cnt_d = '0;
                ovf_d     = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Code_Valid is a one-cycle strobe with no back-pressure: Code is valid
    // exactly in the cycle Code_Valid is high, and simply holds afterwards.
    assign Code       = code_q;
    assign Code_Valid = (state_q == ST_EMIT);
    assign Sym_Count  = sym_cnt_q;
    assign Busy       = (state_q != ST_IDLE);
    assign Dbg_State  = state_q;

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 SHALL have parameter DOT_MAX, default 2: a press of DOT_MAX Ticks or fewer is a dot; a longer press is a dash.
REQ-002 SHALL have parameter GAP_LETTER, default 3: the number of released Ticks that ends a letter.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock. Every flop is on posedge Clk.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Tick, input, 1 bit: single-cycle time-unit enable, generated from the divided clock.
REQ-006 SHALL have port Key, input, 1 bit: debounced key level; 1 means pressed.
REQ-007 SHALL have port Code, output, 6 bits: decoded symbol. 0-25 are A-Z, 26-35 are digits 0-9, 63 is invalid.
REQ-008 SHALL have port Code_Valid, output, 1 bit: one-cycle strobe qualifying Code.
REQ-009 SHALL have port Sym_Count, output, 3 bits: number of symbols accumulated in the current letter.
REQ-010 SHALL have port Busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, MARK, SPACE and EMIT, held in a registered state register.
REQ-012 SHALL go from IDLE to MARK in the cycle after Key is sampled 1, clearing the tick counter.
REQ-013 SHALL, in MARK, increment the 8-bit tick counter on each Tick. The counter saturates at 255 and does not wrap.
REQ-014 SHALL, when Key is sampled 0 in MARK, classify the press and store it:
- dot (0) if the count is <= DOT_MAX, dash (1) otherwise;
- store the symbol at bit position Sym_Count of the pattern register (the first symbol goes in bit 0);
- increment Sym_Count, clear the counter and enter SPACE.
REQ-015 SHALL, when Key is sampled 1 in SPACE, return to MARK with the counter cleared. This is an intra-letter gap.
REQ-016 SHALL, in SPACE, increment the counter on each Tick. When the counter reaches GAP_LETTER, the next state is EMIT.
REQ-017 SHALL hold EMIT for exactly one cycle, with Code_Valid=1 and Code driven from the lookup, then go to IDLE.
- On entry to IDLE, the pattern, Sym_Count and the overflow flag are cleared.
REQ-018 SHALL ignore Key while in EMIT. A press held through EMIT is picked up from IDLE on the following cycle.
REQ-019 SHALL set the sticky overflow flag if a symbol arrives when Sym_Count already equals the maximum length. That symbol is discarded.
REQ-020 SHALL emit Code=63 in EMIT when overflow is set or the pattern/length pair has no table entry.
REQ-021 SHALL decode letters from a complete table of the 26 A-Z patterns of length 1-4.
REQ-022 SHALL hold Code at its last emitted value outside EMIT; Code_Valid is 0 outside EMIT.
REQ-023 SHALL define the latency: Code_Valid asserts one cycle after the Tick on which the gap count reaches GAP_LETTER.
REQ-024 SHALL handle a Tick and a Key edge in the same cycle as follows: the edge takes priority and the Tick is not counted.

Reset
REQ-025 SHALL, while Reset=1 at a clock edge:
- set the state to IDLE;
- set Code=0, Code_Valid=0, Sym_Count=0 and Busy=0;
- clear the counter, the pattern register and the overflow flag.
REQ-026 SHALL abandon any partial letter on a reset mid-operation, with no emit.

Configuration
REQ-027 SHALL, with MORSE_DIGITS_EN defined, set the maximum length to 5 and decode the ten 5-symbol digit patterns to codes 26-35.
REQ-028 SHALL, without MORSE_DIGITS_EN, set the maximum length to 4. A fifth symbol sets overflow, and codes 26-35 are never produced.

Structure
REQ-029 SHALL place the state encodings, the code constants (CODE_A=0, CODE_DIGIT0=26, CODE_INVALID=63) and the maximum-length constants in shared package morse_pkg.
REQ-030 SHALL implement the pattern/length-to-code table as a combinational sub-module, morse_lut, instantiated once.

Verification (all scenarios use DOT_MAX=2 and GAP_LETTER=3)
REQ-031 SHALL cover the letter A:
- Stimulus: press 1 Tick, release 1 Tick, press 4 Ticks, release 3 Ticks.
- Required response: a single Code_Valid with Code=0, and Sym_Count was 2 before the emit.
REQ-032 SHALL cover the letter E:
- Stimulus: press 2 Ticks (boundary), then release.
- Required response: Code=4 is emitted.
- Also: a press of 3 Ticks followed by release gives Code=19 (T).
REQ-033 SHALL cover overflow without MORSE_DIGITS_EN:
- Stimulus: five dots.
- Required response: Code=63.
- With MORSE_DIGITS_EN defined, the same stimulus gives Code=31 (digit 5).
REQ-034 SHALL cover reset mid-letter:
- Stimulus: assert Reset after two symbols, then send a single dash.
- Required response: Code=19, and no emit occurs for the partial letter.
REQ-035 SHALL cover a held press:
- Stimulus: hold Key for 300 Ticks.
- Required response: the counter saturates at 255 and the press is classified as a dash, giving Code=19 (T).
REQ-036 SHALL cover a Tick coincident with a release edge:
- Stimulus: assert Tick in the same cycle as the release edge at count 2.
- Required response: the press is classified as a dot, and the gap count starts at 0.
